sd_block_read: RTL and testbench

//  SPI-mode single-block read engine (CMD17), downstream of the SD init stage.

---
 rtl/sd_block_read.sv | 306 ++++++++++++++++++++++++++++++
 tb/tb_sd_block_read.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/sd_block_read.sv
// sd_block_read: SPI-mode CMD17 single-block read engine; sends the command, parses R1,
// the start token, 512 data bytes and CRC, and streams the bytes out. Define SD_CRC16_CHECK_EN to verify the data CRC.
module sd_block_read #(
    parameter int RESP_TIMEOUT  = 64,
    parameter int TOKEN_TIMEOUT = 4096,
    parameter int TAIL_CLKS     = 8
) (
    input  logic        SD_CK,
    input  logic        rst,
    input  logic        init_i,
    input  logic        rd_req,
    input  logic [31:0] rd_addr,
    output logic        busy,
    output logic        rd_valid,
    output logic [7:0]  rd_data,
    output logic [8:0]  rd_idx,
    output logic        done,
    output logic [2:0]  err_code,
    input  logic        SD_MISO,
    output logic        SD_MOSI,
    output logic        SD_CSn
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SEND     = 3'd1,
        ST_R1_WAIT  = 3'd2,
        ST_R1_RX    = 3'd3,
        ST_TOK_WAIT = 3'd4,
        ST_DATA     = 3'd5,
        ST_CRC      = 3'd6,
        ST_TAIL     = 3'd7
    } state_t;

    localparam logic [15:0] RESP_LOAD  = 16'(RESP_TIMEOUT);
    localparam logic [15:0] TOKEN_LOAD = 16'(TOKEN_TIMEOUT);
    localparam logic [7:0]  TAIL_LOAD  = 8'(TAIL_CLKS - 1);
    localparam logic [2:0]  ERR_OK      = 3'd0;
    localparam logic [2:0]  ERR_R1_TMO  = 3'd1;
    localparam logic [2:0]  ERR_R1_BAD  = 3'd2;
    localparam logic [2:0]  ERR_TOK_TMO = 3'd3;
    localparam logic [2:0]  ERR_NOINIT  = 3'd5;

    function automatic logic [12:0] bit_dec(input logic [12:0] b);
        if (b == 13'd0) begin
            return 13'd0;
        end else begin
            return b - 13'd1;
        end
    endfunction

`ifdef SD_CRC16_CHECK_EN
    localparam logic [2:0] ERR_CRC = 3'd4;

    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
        logic fb;
        fb = crc[15] ^ din;
        return {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    endfunction

    logic [15:0] crc_calc_q, crc_calc_d;
    logic [14:0] crc_rx_q, crc_rx_d;
`endif

    state_t      state_q, state_d;
    logic [46:0] frame_q, frame_d;
    logic [12:0] bitcnt_q, bitcnt_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  tcnt_q, tcnt_d;
    logic        r1_nz_q, r1_nz_d;
    logic [6:0]  sr_q, sr_d;
    logic [8:0]  byte_idx_q, byte_idx_d;
    logic [2:0]  err_q, err_d;
    logic        busy_q, busy_d;
    logic        rd_valid_q, rd_valid_d;
    logic [7:0]  rd_data_q, rd_data_d;
    logic [8:0]  rd_idx_q, rd_idx_d;
    logic        done_q, done_d;
    logic [2:0]  err_code_q, err_code_d;
    logic        mosi_q, mosi_d;
    logic        csn_q, csn_d;
    logic [47:0] cmd_s;
    logic        fin_s;
    logic [2:0]  fin_err_s;
    logic        reject_s;

    // Next-state, datapath and output computation
    always_comb begin
        state_d    = state_q;
        frame_d    = frame_q;
        bitcnt_d   = bitcnt_q;
        cnt_d      = cnt_q;
        tcnt_d     = tcnt_q;
        r1_nz_d    = r1_nz_q;
        sr_d       = sr_q;
        byte_idx_d = byte_idx_q;
        err_d      = err_q;
        rd_valid_d = 1'b0;
        rd_data_d  = rd_data_q;
        rd_idx_d   = rd_idx_q;
        done_d     = 1'b0;
        err_code_d = err_code_q;
        mosi_d     = 1'b1;
        fin_s      = 1'b0;
        fin_err_s  = ERR_OK;
        reject_s   = 1'b0;
        cmd_s      = {8'h51, rd_addr, 8'hFF};
`ifdef SD_CRC16_CHECK_EN
        crc_calc_d = crc_calc_q;
        crc_rx_d   = crc_rx_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (rd_req && init_i) begin
                    state_d  = ST_SEND;
                    mosi_d   = cmd_s[47];
                    frame_d  = cmd_s[46:0];
                    bitcnt_d = 13'd47;
`ifdef SD_CRC16_CHECK_EN
                    crc_calc_d = 16'h0000;
`endif
                end else begin
                    reject_s = rd_req;
                end
            end
            ST_SEND: begin
                if (bitcnt_q == 13'd0) begin
                    state_d = ST_R1_WAIT;
                    cnt_d   = RESP_LOAD;
                end else begin
                    mosi_d   = frame_q[46];
                    frame_d  = {frame_q[45:0], 1'b1};
                    bitcnt_d = bit_dec(bitcnt_q);
                end
            end
            ST_R1_WAIT: begin
                if (!SD_MISO) begin
                    state_d  = ST_R1_RX;
                    r1_nz_d  = 1'b0;
                    bitcnt_d = 13'd7;
                end else if (cnt_q <= 16'd1) begin
                    fin_s     = 1'b1;
                    fin_err_s = ERR_R1_TMO;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            ST_R1_RX: begin
                r1_nz_d  = r1_nz_q | SD_MISO;
                bitcnt_d = bit_dec(bitcnt_q);
                if (bitcnt_q == 13'd1) begin
                    if (r1_nz_d) begin
                        fin_s     = 1'b1;
                        fin_err_s = ERR_R1_BAD;
                    end else begin
                        state_d = ST_TOK_WAIT;
                        cnt_d   = TOKEN_LOAD;
                    end
                end else begin
                    state_d = ST_R1_RX;
                end
            end
            ST_TOK_WAIT: begin
                // Leading ones of 0xFE look like idle bus; the single zero ends the token
                if (!SD_MISO) begin
                    state_d    = ST_DATA;
                    bitcnt_d   = 13'd4096;
                    byte_idx_d = 9'd0;
                end else if (cnt_q <= 16'd1) begin
                    fin_s     = 1'b1;
                    fin_err_s = ERR_TOK_TMO;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            ST_DATA: begin
                sr_d     = {sr_q[5:0], SD_MISO};
                bitcnt_d = bit_dec(bitcnt_q);
`ifdef SD_CRC16_CHECK_EN
                crc_calc_d = crc16_step(crc_calc_q, SD_MISO);
`endif
                if (bitcnt_q[2:0] == 3'd1) begin
                    rd_valid_d = 1'b1;
                    rd_data_d  = {sr_q, SD_MISO};
                    rd_idx_d   = byte_idx_q;
                    byte_idx_d = byte_idx_q + 9'd1;
                end else begin
                    rd_valid_d = 1'b0;
                end
                if (bitcnt_q == 13'd1) begin
                    state_d  = ST_CRC;
                    bitcnt_d = 13'd16;
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_CRC: begin
                bitcnt_d = bit_dec(bitcnt_q);
`ifdef SD_CRC16_CHECK_EN
                crc_rx_d = {crc_rx_q[13:0], SD_MISO};
`endif
                if (bitcnt_q == 13'd1) begin
                    fin_s = 1'b1;
`ifdef SD_CRC16_CHECK_EN
                    fin_err_s = ({crc_rx_q, SD_MISO} == crc_calc_q) ? ERR_OK : ERR_CRC;
`else
                    fin_err_s = ERR_OK;
`endif
                end else begin
                    fin_s = 1'b0;
                end
            end
            ST_TAIL: begin
                if (tcnt_q == 8'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    tcnt_d = tcnt_q - 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (fin_s) begin
            state_d = ST_TAIL;
            tcnt_d  = TAIL_LOAD;
            err_d   = fin_err_s;
        end else begin
            err_d = err_q;
        end

        csn_d  = (state_d == ST_IDLE) || (state_d == ST_TAIL);
        busy_d = (state_d != ST_IDLE);

        // done marks the last TAIL cycle, or the cycle after a request made before init
        if (reject_s) begin
            done_d     = 1'b1;
            err_code_d = ERR_NOINIT;
        end else if ((state_d == ST_TAIL) && (tcnt_d == 8'd0)) begin
            done_d     = 1'b1;
            err_code_d = err_d;
        end else begin
            done_d = 1'b0;
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge SD_CK) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            frame_q    <= 47'h7FFF_FFFF_FFFF;
            bitcnt_q   <= 13'd0;
            cnt_q      <= 16'd0;
            tcnt_q     <= 8'd0;
            r1_nz_q    <= 1'b0;
            sr_q       <= 7'd0;
            byte_idx_q <= 9'd0;
            err_q      <= 3'd0;
            busy_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= 8'd0;
            rd_idx_q   <= 9'd0;
            done_q     <= 1'b0;
            err_code_q <= 3'd0;
            mosi_q     <= 1'b1;
            csn_q      <= 1'b1;
`ifdef SD_CRC16_CHECK_EN
            crc_calc_q <= 16'h0000;
            crc_rx_q   <= 15'h0000;
`endif
        end else begin
            state_q    <= state_d;
            frame_q    <= frame_d;
            bitcnt_q   <= bitcnt_d;
            cnt_q      <= cnt_d;
            tcnt_q     <= tcnt_d;
            r1_nz_q    <= r1_nz_d;
            sr_q       <= sr_d;
            byte_idx_q <= byte_idx_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            rd_idx_q   <= rd_idx_d;
            done_q     <= done_d;
            err_code_q <= err_code_d;
            mosi_q     <= mosi_d;
            csn_q      <= csn_d;
`ifdef SD_CRC16_CHECK_EN
            crc_calc_q <= crc_calc_d;
            crc_rx_q   <= crc_rx_d;
`endif
        end
    end

    assign busy     = busy_q;
    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
    assign rd_idx   = rd_idx_q;
    assign done     = done_q;
    assign err_code = err_code_q;
    assign SD_MOSI  = mosi_q;
    assign SD_CSn   = csn_q;

endmodule

// File: tb/tb_sd_block_read.sv
// tb_sd_block_read: table-driven bench for sd_block_read with a bit-level card model on SD_MISO.
module tb_sd_block_read;

    localparam int RT = 64;
    localparam int TT = 4096;
    localparam int TC = 8;
`ifdef SD_CRC16_CHECK_EN
    localparam logic [2:0] CRC_BAD_ERR = 3'd4;
`else
    localparam logic [2:0] CRC_BAD_ERR = 3'd0;
`endif

    logic        SD_CK = 1'b0;
    logic        rst;
    logic        init_i;
    logic        rd_req;
    logic [31:0] rd_addr;
    logic        busy;
    logic        rd_valid;
    logic [7:0]  rd_data;
    logic [8:0]  rd_idx;
    logic        done;
    logic [2:0]  err_code;
    logic        SD_MISO;
    logic        SD_MOSI;
    logic        SD_CSn;

    sd_block_read #(
        .RESP_TIMEOUT (RT),
        .TOKEN_TIMEOUT(TT),
        .TAIL_CLKS    (TC)
    ) dut (
        .SD_CK   (SD_CK),
        .rst     (rst),
        .init_i  (init_i),
        .rd_req  (rd_req),
        .rd_addr (rd_addr),
        .busy    (busy),
        .rd_valid(rd_valid),
        .rd_data (rd_data),
        .rd_idx  (rd_idx),
        .done    (done),
        .err_code(err_code),
        .SD_MISO (SD_MISO),
        .SD_MOSI (SD_MOSI),
        .SD_CSn  (SD_CSn)
    );

    always #5 SD_CK = ~SD_CK;

    int tests = 0;
    int fails = 0;

    typedef struct {
        string       name;
        logic        init;
        logic [31:0] addr;
        int          r1_lead;     // ones before R1; -1 = card never answers
        logic [7:0]  r1;
        int          tok_lead;    // ones before 0xFE; -1 = token never sent
        logic [7:0]  seed;        // byte k = k + seed
        logic        crc_flip;
        int          extra_req_n; // cycle of an extra rd_req while busy; -1 = none
        int          rst_idx;     // rd_idx at which rst is pulsed; -1 = none
        logic [2:0]  exp_err;
        int          exp_bytes;
        int          exp_done_n;  // cycles after accept edge; -1 = no done expected
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] crc16_ccitt(input logic [15:0] crc, input logic din);
        logic fb;
        fb = crc[15] ^ din;
        return {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    endfunction

    task automatic run_vec(input vec_t v);
        bit          q[$];
        logic [15:0] crc;
        logic [7:0]  b;
        logic [7:0]  tok;
        logic [7:0]  exp_b;
        logic [47:0] frame;
        int          n;
        int          budget;
        int          nbytes;
        int          done_n;
        logic        done_seen;
        logic        post_done;
        logic        rst_done;
        logic        csn_bad;
        logic        busy_bad;
        logic [2:0]  done_err;
        logic        done_csn;
        logic        done_mosi;

        tok = 8'hFE;
        crc = 16'h0000;
        if (v.r1_lead >= 0) begin
            repeat (v.r1_lead) q.push_back(1'b1);
            for (int i = 7; i >= 0; i--) q.push_back(v.r1[i]);
            if (v.tok_lead >= 0) begin
                repeat (v.tok_lead) q.push_back(1'b1);
                for (int i = 7; i >= 0; i--) q.push_back(tok[i]);
                for (int k = 0; k < 512; k++) begin
                    b = 8'(k) + v.seed;
                    for (int i = 7; i >= 0; i--) begin
                        q.push_back(b[i]);
                        crc = crc16_ccitt(crc, b[i]);
                    end
                end
                if (v.crc_flip) crc = crc ^ 16'h0001;
                for (int i = 15; i >= 0; i--) q.push_back(crc[i]);
            end
        end

        @(negedge SD_CK);
        init_i  = v.init;
        rd_addr = v.addr;
        rd_req  = 1'b1;

        n = 0; nbytes = 0; done_n = -1; frame = 48'd0;
        done_seen = 1'b0; post_done = 1'b0; rst_done = 1'b0;
        csn_bad = 1'b0; busy_bad = 1'b0;
        done_err = 3'd0; done_csn = 1'b0; done_mosi = 1'b0;
        budget = (v.exp_done_n >= 0) ? v.exp_done_n + 40 : 6000;

        while (!done_seen && !rst_done && n <= budget) begin
            @(negedge SD_CK);
            rd_req = (n == v.extra_req_n);
            if (n >= 48 && q.size() > 0) SD_MISO = q.pop_front();
            else SD_MISO = 1'b1;
            if (n < 48) begin
                frame = {frame[46:0], SD_MOSI};
                if (SD_CSn !== !v.init) csn_bad = 1'b1;
                if (busy !== v.init) busy_bad = 1'b1;
            end
            if (done) begin
                done_seen = 1'b1;
                done_n    = n;
                done_err  = err_code;
                done_csn  = SD_CSn;
                done_mosi = SD_MOSI;
                if (v.init) rd_req = 1'b1;
            end
            if (rd_valid) begin
                exp_b = 8'(nbytes) + v.seed;
                chk({v.name, "_byte"}, {rd_idx, rd_data}, {9'(nbytes), exp_b});
                nbytes++;
                if (v.rst_idx >= 0 && rd_idx == 9'(v.rst_idx)) begin
                    rst = 1'b1;
                    @(negedge SD_CK);
                    chk({v.name, "_rst_csn"}, SD_CSn, 1'b1);
                    chk({v.name, "_rst_busy"}, busy, 1'b0);
                    chk({v.name, "_rst_valid"}, rd_valid, 1'b0);
                    rst = 1'b0;
                    SD_MISO = 1'b1;
                    repeat (40) begin
                        @(negedge SD_CK);
                        if (done) post_done = 1'b1;
                    end
                    rst_done = 1'b1;
                end
            end
            n++;
        end

        if (rst_done) begin
            chk({v.name, "_no_done_after_rst"}, post_done, 1'b0);
            chk({v.name, "_bytes"}, nbytes, v.exp_bytes);
        end else begin
            chk({v.name, "_done_seen"}, done_seen, 1'b1);
            chk({v.name, "_done_cycle"}, done_n, v.exp_done_n);
            chk({v.name, "_err"}, done_err, v.exp_err);
            chk({v.name, "_bytes"}, nbytes, v.exp_bytes);
            chk({v.name, "_csn_at_done"}, done_csn, 1'b1);
            chk({v.name, "_mosi_at_done"}, done_mosi, 1'b1);
            @(negedge SD_CK);
            rd_req = 1'b0;
            chk({v.name, "_done_one_cycle"}, done, 1'b0);
            chk({v.name, "_busy_after"}, busy, 1'b0);
            chk({v.name, "_err_hold"}, err_code, v.exp_err);
            chk({v.name, "_csn_idle"}, SD_CSn, 1'b1);
        end
        if (v.init) chk({v.name, "_frame"}, frame, {8'h51, v.addr, 8'hFF});
        chk({v.name, "_csn_window"}, csn_bad, 1'b0);
        chk({v.name, "_busy_window"}, busy_bad, 1'b0);
        rd_req  = 1'b0;
        SD_MISO = 1'b1;
        repeat (3) @(negedge SD_CK);
    endtask

    initial begin
        //          name         init addr          lead r1     tok  seed   flip extra rst  err          bytes done
        vecs[0] = '{"rd_ok",     1'b1, 32'h0000_0010, 3,  8'h00, 10,  8'h00, 1'b0, 2000, -1, 3'd0,        512,  4196};
        vecs[1] = '{"r1_tmo",    1'b1, 32'h0000_0001, -1, 8'h00, -1,  8'h00, 1'b0, -1,   -1, 3'd1,        0,    47 + RT + TC};
        vecs[2] = '{"r1_bad",    1'b1, 32'h0000_0002, 63, 8'h05, -1,  8'h00, 1'b0, -1,   -1, 3'd2,        0,    126};
        vecs[3] = '{"tok_tmo",   1'b1, 32'h0000_0003, 3,  8'h00, -1,  8'h00, 1'b0, 300,  -1, 3'd3,        0,    66 + TT};
        vecs[4] = '{"crc_bad",   1'b1, 32'hDEAD_BEEF, 3,  8'h00, 10,  8'h5A, 1'b1, -1,   -1, CRC_BAD_ERR, 512,  4196};
        vecs[5] = '{"no_init",   1'b0, 32'h0000_1234, -1, 8'h00, -1,  8'h00, 1'b0, -1,   -1, 3'd5,        0,    0};
        vecs[6] = '{"rst_mid",   1'b1, 32'h0000_0020, 3,  8'h00, 10,  8'h00, 1'b0, -1,  100, 3'd0,        101,  -1};
        vecs[7] = '{"rd_fresh",  1'b1, 32'hFFFF_FFFF, 0,  8'h00, 0,   8'hC3, 1'b0, -1,   -1, 3'd0,        512,  4183};

        rst     = 1'b1;
        init_i  = 1'b0;
        rd_req  = 1'b0;
        rd_addr = 32'd0;
        SD_MISO = 1'b1;
        repeat (3) @(negedge SD_CK);
        chk("reset_busy", busy, 1'b0);
        chk("reset_rd_valid", rd_valid, 1'b0);
        chk("reset_rd_data", rd_data, 8'd0);
        chk("reset_rd_idx", rd_idx, 9'd0);
        chk("reset_done", done, 1'b0);
        chk("reset_err_code", err_code, 3'd0);
        chk("reset_mosi", SD_MOSI, 1'b1);
        chk("reset_csn", SD_CSn, 1'b1);
        rst = 1'b0;
        repeat (2) @(negedge SD_CK);

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
